instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries, a power of two from 2 to 16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  32  word address of the outstanding request.
REQ-007 imem_ack  in  1  request accepted; imem_rdata is valid this cycle.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 redirect  in  1  branch/jump taken in decode; restart fetch.
REQ-010 redirect_pc  in  32  new fetch address; sampled when redirect=1.
REQ-011 stall  in  1  decode not accepting (Stall_D from hazard unit).
REQ-012 instr_valid  out  1  queue head holds a valid instruction.
REQ-013 instr  out  32  head instruction (feeds the decode register in place of instr_F).
REQ-014 instr_pc_plus4  out  32  head instruction address + 4 (feeds the decode pc_plus4 register).

Function
REQ-015 Handshake: once imem_req=1, imem_req and imem_addr SHALL hold stable until the imem_ack cycle; at most one request is outstanding.
REQ-016 The FSM SHALL have three states:
- IDLE: imem_req=0.
- REQ: imem_req=1, waiting for ack.
- DRAIN: imem_req=1, waiting for an ack whose data is discarded.
REQ-017 IDLE -> REQ when count_next < DEPTH; address = fetch_pc.
REQ-018 REQ with ack, no redirect: push {rdata, addr+4}; fetch_pc += 4; stay in REQ with the new address when count_next < DEPTH (back-to-back, no bubble), else go to IDLE.
REQ-019 Redirect in any state: flush the FIFO (count=0, pointers reset) and set fetch_pc = redirect_pc.
- From REQ without ack in the same cycle: go to DRAIN.
- From REQ with ack in the same cycle: discard the ack data and go to REQ at redirect_pc.
- From IDLE: go to REQ at redirect_pc.
REQ-020 DRAIN with ack: discard data; go to REQ at fetch_pc. A redirect in DRAIN only updates fetch_pc.
REQ-021 Pop occurs when instr_valid=1, stall=0, and redirect=0. A redirect overrides a same-cycle pop and push.
REQ-022 count_next = count + push - pop; a simultaneous push and pop leaves count unchanged; the FIFO SHALL never overflow.
REQ-023 instr_valid = (count != 0) and the FIFO is not being flushed this cycle; instr and instr_pc_plus4 come from the head entry.
REQ-024 FIFO pointers wrap modulo DEPTH; PC arithmetic wraps modulo 2^32.
REQ-025 Latency: from the ack edge to instr_valid SHALL be one cycle (without the bypass of REQ-029).

Reset
REQ-026 While rst=0, all of the following SHALL hold: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc_plus4=0.
REQ-027 Reset asserted mid-request SHALL abandon the request; any late ack after reset release, arriving while imem_req=0, SHALL be ignored.
REQ-028 The first imem_req SHALL assert one cycle after rst deasserts, with imem_addr=RESET_PC.

Configuration
REQ-029 With IFQ_BYPASS_EN defined: when count=0 and a non-discarded ack arrives, instr_valid, instr and instr_pc_plus4 SHALL present the ack data combinationally in the same cycle. If it is popped that cycle, it is not written to the FIFO.
REQ-030 Without IFQ_BYPASS_EN: no combinational path from the imem_* inputs to the instr* outputs; one-cycle latency per REQ-025.

Structure
REQ-031 Package ifq_pkg SHALL hold the FSM state enum (IDLE/REQ/DRAIN), INSTR_W=32, ADDR_W=32, and the RESET_PC default.
REQ-032 Sub-module ifq_fifo SHALL implement circular storage only (push, pop, flush, head, count). The FSM and PC logic live in instr_fetch_queue.

Verification
REQ-033 Reset, then ack every cycle, stall=0 -> addresses 0x0,0x4,0x8 issued on consecutive cycles; instr_pc_plus4 sequence 0x4,0x8,0xC; no bubbles after the first.
REQ-034 stall=1 held, ack every cycle, DEPTH=4 -> exactly 4 pushes; imem_req drops to 0; count=4; head unchanged; release stall -> fetch resumes at 0x10.
REQ-035 Redirect to 0x100 while REQ at 0x8 is unacked, ack arrives 3 cycles later -> data discarded; imem_addr holds 0x8 until that ack; next request is 0x100; no 0x8 instruction reaches decode.
REQ-036 Redirect to 0x200 in the same cycle as an ack for 0xC, with 2 entries queued -> instr_valid=0 next cycle; next imem_addr=0x200.
REQ-037 Assert rst=0 while REQ at 0x14 is outstanding -> all outputs zero immediately (async); after release, first request is RESET_PC.
REQ-038 IFQ_BYPASS_EN defined, empty FIFO, ack with 0x2402_0005 -> instr=0x2402_0005 and instr_valid=1 in the ack cycle; count stays 0 when popped.

Source files
------------

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared widths, FSM state encoding and queue entry layout for the instruction fetch queue.
package ifq_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2} ifq_state_e;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0] pc_plus4;
  } ifq_entry_t;
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: circular entry storage with push, pop, flush, head and occupancy; no flow-control policy.
module ifq_fifo import ifq_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  ifq_entry_t    din_i,
  output ifq_entry_t    head_o,
  output logic [CW-1:0] count_o
);
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  ifq_entry_t mem_q [DEPTH];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  always_ff @(posedge clk)
    if (push_i && !flush_i) mem_q[wr_q] <= din_i;
  assign head_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: single-outstanding fetch FSM feeding a small instruction queue toward decode.
// Define IFQ_BYPASS_EN to forward an ack straight to the outputs when the queue is empty.
module instr_fetch_queue import ifq_pkg::*; #(
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               stall,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc_plus4
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  ifq_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [CW-1:0] count, count_next;
  logic take, bypass, pop, fifo_pop, push, room;
  ifq_entry_t head, din;
  assign take = state_q == REQ && imem_ack && !redirect;
  assign din = {imem_rdata, addr_q + 32'd4};
`ifdef IFQ_BYPASS_EN
  assign bypass = take && count == '0;
`else
  assign bypass = 1'b0;
`endif
  assign instr_valid = (count != '0 && !redirect) || bypass;
  assign pop = instr_valid && !stall;
  assign fifo_pop = pop && !bypass;
  // A bypassed word consumed in its own ack cycle never enters storage.
  assign push = take && !(bypass && pop);
  assign count_next = redirect ? '0 : count + CW'(push) - CW'(fifo_pop);
  assign room = count_next < DEPTH_C;
  assign instr = !instr_valid ? '0 : bypass ? imem_rdata : head.instr;
  assign instr_pc_plus4 = !instr_valid ? '0 : bypass ? din.pc_plus4 : head.pc_plus4;
  assign imem_req = state_q != IDLE;
  assign imem_addr = addr_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    addr_d = addr_q;
    case (state_q)
      IDLE: begin
        state_d = redirect || room ? REQ : IDLE;
        pc_d = redirect ? redirect_pc : pc_q;
        addr_d = redirect ? redirect_pc : room ? pc_q : addr_q;
      end
      REQ:
        if (redirect) begin
          pc_d = redirect_pc;
          addr_d = imem_ack ? redirect_pc : addr_q;
          state_d = imem_ack ? REQ : DRAIN;
        end else if (imem_ack) begin
          pc_d = pc_q + 32'd4;
          addr_d = pc_q + 32'd4;
          state_d = room ? REQ : IDLE;
        end
      DRAIN: begin
        pc_d = redirect ? redirect_pc : pc_q;
        addr_d = imem_ack ? pc_d : addr_q;
        state_d = imem_ack ? REQ : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
    end
  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .din_i   (din),
    .head_o  (head),
    .count_o (count)
  );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed checks of fetch handshake, backpressure, redirect, reset and bypass.
module tb_instr_fetch_queue;
  logic clk = 1'b0, rst = 1'b0, imem_ack = 1'b0, redirect = 1'b0, stall = 1'b0, use_k = 1'b0;
  logic imem_req, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc_plus4;
  logic [31:0] redirect_pc = 32'h0;
  int n_chk = 0, n_pass = 0;
`ifdef IFQ_BYPASS_EN
  localparam int OFS = 4;
`else
  localparam int OFS = 0;
`endif
  always #5 clk = ~clk;
  assign imem_rdata = use_k ? 32'h2402_0005 : {16'hC0DE, imem_addr[15:0]};
  instr_fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc_plus4 (instr_pc_plus4)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic fresh;
    rst = 1'b0;
    imem_ack = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;
    use_k = 1'b0;
    tick;
    rst = 1'b1;
  endtask
  initial begin
    tick;
    check("rst_req", 32'(imem_req), 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_instr", instr, 0);
    check("rst_pc4", instr_pc_plus4, 0);
    rst = 1'b1;
    tick;
    check("first_req", 32'(imem_req), 1);
    check("first_addr", imem_addr, 0);
    imem_ack = 1'b1;
    tick;
    for (int i = 0; i < 6; i++) begin
      check("stream_addr", imem_addr, 32'(4 * (i + 1)));
      check("stream_pc4", instr_pc_plus4, 32'(4 * (i + 1) + OFS));
      check("stream_instr", instr, 32'hC0DE_0000 | 32'(4 * i + OFS));
      tick;
    end
    fresh;
    stall = 1'b1;
    tick;
    imem_ack = 1'b1;
    repeat (4) tick;
    check("full_req", 32'(imem_req), 0);
    check("full_valid", 32'(instr_valid), 1);
    check("full_head", instr_pc_plus4, 32'h4);
    repeat (3) tick;
    check("full_hold_req", 32'(imem_req), 0);
    check("full_hold_head", instr_pc_plus4, 32'h4);
    check("full_hold_instr", instr, 32'hC0DE_0000);
    stall = 1'b0;
    tick;
    check("resume_req", 32'(imem_req), 1);
    check("resume_addr", imem_addr, 32'h10);
    check("resume_head", instr_pc_plus4, 32'h8);
    fresh;
    tick;
    imem_ack = 1'b1;
    tick;
    tick;
    check("drain_pre_addr", imem_addr, 32'h8);
    imem_ack = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    #1 check("flush_valid", 32'(instr_valid), 0);
    tick;
    redirect = 1'b0;
    check("drain_req", 32'(imem_req), 1);
    check("drain_addr", imem_addr, 32'h8);
    check("drain_valid", 32'(instr_valid), 0);
    tick;
    tick;
    check("drain_hold_addr", imem_addr, 32'h8);
    imem_ack = 1'b1;
    tick;
    imem_ack = 1'b0;
    #1 check("redir_addr", imem_addr, 32'h100);
    check("discard_valid", 32'(instr_valid), 0);
    stall = 1'b1;
    imem_ack = 1'b1;
    tick;
    imem_ack = 1'b0;
    #1 check("redir_valid", 32'(instr_valid), 1);
    check("redir_pc4", instr_pc_plus4, 32'h104);
    check("redir_instr", instr, 32'hC0DE_0100);
    fresh;
    stall = 1'b1;
    tick;
    imem_ack = 1'b1;
    tick;
    tick;
    stall = 1'b0;
    tick;
    check("ackredir_head", instr_pc_plus4, 32'h8);
    check("ackredir_addr", imem_addr, 32'hC);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick;
    redirect = 1'b0;
    imem_ack = 1'b0;
    #1 check("ackredir_valid", 32'(instr_valid), 0);
    check("ackredir_req", 32'(imem_req), 1);
    check("ackredir_newaddr", imem_addr, 32'h200);
    fresh;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    stall = 1'b1;
    imem_ack = 1'b1;
    tick;
    imem_ack = 1'b0;
    #1 check("wrap_pc4", instr_pc_plus4, 32'h0);
    check("wrap_next", imem_addr, 32'h0);
    check("wrap_valid", 32'(instr_valid), 1);
    fresh;
    tick;
    imem_ack = 1'b1;
    repeat (5) tick;
    check("mid_addr", imem_addr, 32'h14);
    imem_ack = 1'b0;
    #2 rst = 1'b0;
    #1 check("async_req", 32'(imem_req), 0);
    check("async_addr", imem_addr, 0);
    check("async_valid", 32'(instr_valid), 0);
    check("async_instr", instr, 0);
    check("async_pc4", instr_pc_plus4, 0);
    tick;
    imem_ack = 1'b1;
    rst = 1'b1;
    tick;
    imem_ack = 1'b0;
    #1 check("late_req", 32'(imem_req), 1);
    check("late_addr", imem_addr, 32'h0);
    check("late_valid", 32'(instr_valid), 0);
    fresh;
    tick;
    use_k = 1'b1;
    imem_ack = 1'b1;
    #1;
`ifdef IFQ_BYPASS_EN
    check("byp_valid", 32'(instr_valid), 1);
    check("byp_instr", instr, 32'h2402_0005);
    tick;
    imem_ack = 1'b0;
    #1 check("byp_empty", 32'(instr_valid), 0);
`else
    check("nobyp_valid", 32'(instr_valid), 0);
    tick;
    imem_ack = 1'b0;
    #1 check("nobyp_next_valid", 32'(instr_valid), 1);
    check("nobyp_instr", instr, 32'h2402_0005);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
